// File: rtl/memaccess.sv
// rtl/memaccess.sv - memory stage: data-bus load/store sequencing, lane alignment and writeback slot
module memaccess #(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_result,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [REGW-1:0] in_dst,
  input  logic            in_memread,
  input  logic            in_memwrite,
  input  logic [2:0]      in_funct3,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [2:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_addr_ok,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [REGW-1:0] out_dst,
  output logic            out_misalign
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          state;
  logic [2:0]      lat_funct3;
  logic [REGW-1:0] lat_dst;
  logic            lat_store;

  logic            accept;
  logic            is_mem;
  logic [1:0]      size;
  logic [2:0]      off;
  logic            misalign;
  logic [7:0]      strobe;
  logic [XLEN-1:0] wdata_sh;
  logic [XLEN-1:0] rdata_sh;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] fin_result;
  logic [REGW-1:0] fin_dst;

  assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mem   = in_memread || in_memwrite;
  assign size     = in_funct3[1:0];
  assign off      = in_result[2:0];

  always_comb begin
    misalign = 1'b0;
    strobe   = 8'h00;
    case (size)
      2'd0: begin misalign = 1'b0;            strobe = 8'h01; end
      2'd1: begin misalign = in_result[0];    strobe = 8'h03; end
      2'd2: begin misalign = |in_result[1:0]; strobe = 8'h0F; end
      default: begin misalign = |in_result[2:0]; strobe = 8'hFF; end
    endcase
    strobe = strobe << off;
  end

  assign wdata_sh = in_wdata << {off, 3'b000};

  // Read data arrives as the full aligned word; the latched address selects the lane.
  assign rdata_sh = dresp_data >> {dreq_addr[2:0], 3'b000};

  always_comb begin
    load_val = rdata_sh;
    case (lat_funct3)
      3'b000:  load_val = {{(XLEN-8){rdata_sh[7]}},   rdata_sh[7:0]};
      3'b001:  load_val = {{(XLEN-16){rdata_sh[15]}}, rdata_sh[15:0]};
      3'b010:  load_val = {{(XLEN-32){rdata_sh[31]}}, rdata_sh[31:0]};
      3'b100:  load_val = {{(XLEN-8){1'b0}},  rdata_sh[7:0]};
      3'b101:  load_val = {{(XLEN-16){1'b0}}, rdata_sh[15:0]};
      3'b110:  load_val = {{(XLEN-32){1'b0}}, rdata_sh[31:0]};
      default: load_val = rdata_sh;
    endcase
  end

  assign fin_result = lat_store ? '0 : load_val;
  assign fin_dst    = lat_store ? '0 : lat_dst;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      lat_funct3   <= '0;
      lat_dst      <= '0;
      lat_store    <= 1'b0;
      dreq_valid   <= 1'b0;
      dreq_addr    <= '0;
      dreq_size    <= '0;
      dreq_strobe  <= '0;
      dreq_data    <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_dst      <= '0;
      out_misalign <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid    <= 1'b0;
        out_misalign <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              out_valid    <= 1'b1;
              out_misalign <= 1'b0;
              out_result   <= in_result;
              out_dst      <= in_dst;
            end else if (misalign) begin
              out_valid    <= 1'b1;
              out_misalign <= 1'b1;
              out_result   <= in_result;
              out_dst      <= '0;
            end else begin
              dreq_valid  <= 1'b1;
              dreq_addr   <= in_result;
              dreq_size   <= {1'b0, size};
              dreq_strobe <= in_memwrite ? strobe : 8'h00;
              dreq_data   <= wdata_sh;
              lat_funct3  <= in_funct3;
              lat_dst     <= in_dst;
              lat_store   <= in_memwrite;
              state       <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // data_ok before the address handshake cannot belong to this request.
          if (dresp_addr_ok) begin
            dreq_valid <= 1'b0;
            if (dresp_data_ok) begin
              out_valid    <= 1'b1;
              out_misalign <= 1'b0;
              out_result   <= fin_result;
              out_dst      <= fin_dst;
              state        <= S_IDLE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (dresp_data_ok) begin
            out_valid    <= 1'b1;
            out_misalign <= 1'b0;
            out_result   <= fin_result;
            out_dst      <= fin_dst;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memaccess.sv
// tb/tb_memaccess.sv - directed vector and sequence bench for memaccess
module tb_memaccess;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_result;
  logic [63:0] in_wdata;
  logic [4:0]  in_dst;
  logic        in_memread;
  logic        in_memwrite;
  logic [2:0]  in_funct3;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_dst;
  logic        out_misalign;

  int checks = 0;
  int errors = 0;

  memaccess #(.XLEN(64), .REGW(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result), .in_wdata(in_wdata),
    .in_dst(in_dst), .in_memread(in_memread), .in_memwrite(in_memwrite), .in_funct3(in_funct3),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_dst(out_dst), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] result;
    logic [63:0] wdata;
    logic [4:0]  dst;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] rdata;
    logic [63:0] exp_result;
    logic [4:0]  exp_dst;
    logic        exp_mis;
    logic        exp_req;
    logic [2:0]  exp_size;
    logic [7:0]  exp_strobe;
    logic [63:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  task chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task drive_op(input logic [63:0] res, input logic [63:0] wd, input logic [4:0] dst,
                input logic rd, input logic wr, input logic [2:0] f3);
    in_valid    = 1'b1;
    in_result   = res;
    in_wdata    = wd;
    in_dst      = dst;
    in_memread  = rd;
    in_memwrite = wr;
    in_funct3   = f3;
  endtask

  task run_vec(input vec_t v);
    int lat;
    logic seen, got;
    logic [63:0] c_addr, c_data;
    logic [2:0]  c_size;
    logic [7:0]  c_strobe;
    @(negedge clk);
    drive_op(v.result, v.wdata, v.dst, v.rd, v.wr, v.f3);
    dresp_data = v.rdata;
    chk("in_ready_before_accept", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; seen = 1'b0; got = 1'b0;
    c_addr = '0; c_data = '0; c_size = '0; c_strobe = '0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (dreq_valid && !seen) begin
        seen = 1'b1;
        c_addr = dreq_addr; c_data = dreq_data; c_size = dreq_size; c_strobe = dreq_strobe;
      end
      if (out_valid) got = 1'b1;
    end
    chk("out_valid_seen", got, 1'b1);
    chk("latency", lat, v.exp_lat);
    chk("out_result", out_result, v.exp_result);
    chk("out_misalign", out_misalign, v.exp_mis);
    if (!v.exp_mis) chk("out_dst", out_dst, v.exp_dst);
    chk("dreq_issued", seen, v.exp_req);
    if (v.exp_req) begin
      chk("dreq_addr", c_addr, v.result);
      chk("dreq_size", c_size, v.exp_size);
      chk("dreq_strobe", c_strobe, v.exp_strobe);
      chk("dreq_data", c_data, v.exp_data);
    end
  endtask

  initial begin
    vecs[0]  = '{64'h1234, 64'h0, 5'd5, 1'b0, 1'b0, 3'b000, 64'h0,
                 64'h1234, 5'd5, 1'b0, 1'b0, 3'd0, 8'h00, 64'h0, 1};
    vecs[1]  = '{64'h1003, 64'h0, 5'd7, 1'b1, 1'b0, 3'b000, 64'h0000_0000_8000_0000,
                 64'hFFFF_FFFF_FFFF_FF80, 5'd7, 1'b0, 1'b1, 3'd0, 8'h00, 64'h0, 2};
    vecs[2]  = '{64'h2006, 64'hBEEF, 5'd9, 1'b0, 1'b1, 3'b001, 64'h0,
                 64'h0, 5'd0, 1'b0, 1'b1, 3'd1, 8'hC0, 64'hBEEF_0000_0000_0000, 2};
    vecs[3]  = '{64'h1003, 64'h0, 5'd3, 1'b1, 1'b0, 3'b100, 64'h0000_0000_8000_0000,
                 64'h80, 5'd3, 1'b0, 1'b1, 3'd0, 8'h00, 64'h0, 2};
    vecs[4]  = '{64'h2, 64'h0, 5'd4, 1'b1, 1'b0, 3'b001, 64'h0000_0000_8001_0000,
                 64'hFFFF_FFFF_FFFF_8001, 5'd4, 1'b0, 1'b1, 3'd1, 8'h00, 64'h0, 2};
    vecs[5]  = '{64'h4, 64'h0, 5'd6, 1'b1, 1'b0, 3'b010, 64'h8765_4321_0000_0000,
                 64'hFFFF_FFFF_8765_4321, 5'd6, 1'b0, 1'b1, 3'd2, 8'h00, 64'h0, 2};
    vecs[6]  = '{64'h4, 64'h0, 5'd6, 1'b1, 1'b0, 3'b110, 64'h8765_4321_0000_0000,
                 64'h0000_0000_8765_4321, 5'd6, 1'b0, 1'b1, 3'd2, 8'h00, 64'h0, 2};
    vecs[7]  = '{64'h1004, 64'h0, 5'd2, 1'b1, 1'b0, 3'b011, 64'h0,
                 64'h1004, 5'd0, 1'b1, 1'b0, 3'd0, 8'h00, 64'h0, 1};
    vecs[8]  = '{64'h8, 64'h0, 5'd8, 1'b1, 1'b0, 3'b011, 64'hDEAD_BEEF_CAFE_F00D,
                 64'hDEAD_BEEF_CAFE_F00D, 5'd8, 1'b0, 1'b1, 3'd3, 8'h00, 64'h0, 2};
    vecs[9]  = '{64'h10, 64'h0123_4567_89AB_CDEF, 5'd10, 1'b0, 1'b1, 3'b011, 64'h0,
                 64'h0, 5'd0, 1'b0, 1'b1, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 2};
    vecs[10] = '{64'h1002, 64'h1111, 5'd1, 1'b0, 1'b1, 3'b010, 64'h0,
                 64'h1002, 5'd0, 1'b1, 1'b0, 3'd0, 8'h00, 64'h0, 1};
    vecs[11] = '{64'h7, 64'hAB, 5'd13, 1'b0, 1'b1, 3'b000, 64'h0,
                 64'h0, 5'd0, 1'b0, 1'b1, 3'd0, 8'h80, 64'hAB00_0000_0000_0000, 2};
    vecs[12] = '{64'h6, 64'h0, 5'd12, 1'b1, 1'b0, 3'b101, 64'hF00D_0000_0000_0000,
                 64'hF00D, 5'd12, 1'b0, 1'b1, 3'd1, 8'h00, 64'h0, 2};
    vecs[13] = '{64'h1, 64'h0, 5'd14, 1'b1, 1'b0, 3'b001, 64'h0,
                 64'h1, 5'd0, 1'b1, 1'b0, 3'd0, 8'h00, 64'h0, 1};

    reset = 1'b1;
    drive_op(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 3'b000);
    in_valid = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    out_ready = 1'b1;
    #12;
    chk("reset_dreq_valid", dreq_valid, 1'b0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_misalign", out_misalign, 1'b0);
    chk("reset_out_result", out_result, 64'h0);
    chk("reset_dreq_addr", dreq_addr, 64'h0);
    chk("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Table section: an always-ready bus answers in the request cycle.
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // LWU with a late address handshake and later data.
    @(negedge clk);
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    drive_op(64'h10, 64'h0, 5'd11, 1'b1, 1'b0, 3'b110);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("late_dreq_valid", dreq_valid, 1'b1);
      chk("late_dreq_addr", dreq_addr, 64'h10);
      chk("late_dreq_size", dreq_size, 3'd2);
      chk("late_dreq_strobe", dreq_strobe, 8'h00);
      chk("late_out_valid", out_valid, 1'b0);
      dresp_data_ok = (i == 1);
      dresp_addr_ok = (i == 2);
    end
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    chk("wait_dreq_valid", dreq_valid, 1'b0);
    chk("wait_out_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("wait2_out_valid", out_valid, 1'b0);
    dresp_data = 64'h0000_0000_F234_5678;
    dresp_data_ok = 1'b1;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    chk("lwu_out_valid", out_valid, 1'b1);
    chk("lwu_out_result", out_result, 64'h0000_0000_F234_5678);
    chk("lwu_out_dst", out_dst, 5'd11);

    // Reset while waiting for data: the late response is dropped.
    @(negedge clk);
    drive_op(64'h20, 64'h0, 5'd15, 1'b1, 1'b0, 3'b010);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    chk("rstwait_dreq_valid", dreq_valid, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstwait_no_out_valid", out_valid, 1'b0);
    end

    // Reset while the request is on the bus drops dreq_valid immediately.
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    drive_op(64'h28, 64'h0, 5'd16, 1'b1, 1'b0, 3'b011);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("rstreq_dreq_valid_before", dreq_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("rstreq_dreq_valid_async", dreq_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    run_vec(vecs[0]);

    // Writeback backpressure holds the slot and blocks new ops.
    @(negedge clk);
    out_ready = 1'b0;
    drive_op(64'h55, 64'h0, 5'd2, 1'b0, 1'b0, 3'b000);
    @(posedge clk);
    #1 drive_op(64'h66, 64'h0, 5'd3, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1'b1);
      chk("stall_out_result", out_result, 64'h55);
      chk("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("refill_out_valid", out_valid, 1'b1);
    chk("refill_out_result", out_result, 64'h66);
    chk("refill_out_dst", out_dst, 5'd3);
    @(negedge clk);
    chk("drain_out_valid", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
